// File: rtl/control_unit.sv
// Instruction-sequencing controller for a small accumulator datapath.
// Walks FETCH -> DECODE -> execute, handshakes with memory through
// mem_ready, and traps into a sticky error state if memory stalls too long.
module control_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op_code,
  input  logic       mem_ready,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass_add,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       instr_done,
  output logic       bus_error
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LDA    = 3'd3,
    S_STA    = 3'd4,
    S_JMP    = 3'd5,
    S_ADD    = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic               waiting;
  logic               timeout;

  // A memory access is outstanding in these states; stalling past the limit times out.
  always_comb begin
    waiting = (state == S_FETCH) || (state == S_LDA) ||
              (state == S_STA)   || (state == S_ADD);
    timeout = waiting && !mem_ready && (wait_cnt == CNT_W'(WAIT_LIMIT));
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter restarts on every state change and counts stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (waiting && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag; only reset clears it since ERR is never left otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_error <= 1'b0;
    end else if (state_next == S_ERR) begin
      bus_error <= 1'b1;
    end
  end

  // Next-state and strobe decode; handshake strobes respond to mem_ready in the same cycle.
  always_comb begin
    state_next = state;
    ir_on_adr  = 1'b0;
    pc_on_adr  = 1'b0;
    ld_ir      = 1'b0;
    ld_ac      = 1'b0;
    ld_pc      = 1'b0;
    inc_pc     = 1'b0;
    clr_pc     = 1'b0;
    pass_add   = 1'b0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    instr_done = 1'b0;

    case (state)
      S_RST: begin
        clr_pc     = 1'b1;
        state_next = S_FETCH;
      end

      S_FETCH: begin
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        if (mem_ready) begin
          ld_ir      = 1'b1;
          inc_pc     = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end

      S_DECODE: begin
        case (op_code)
          2'b00:   state_next = S_LDA;
          2'b01:   state_next = S_STA;
          2'b10:   state_next = S_JMP;
          default: state_next = S_ADD;
        endcase
      end

      S_LDA, S_ADD: begin
        ir_on_adr = 1'b1;
        rd_mem    = 1'b1;
        pass_add  = (state == S_ADD);
        if (mem_ready) begin
          ld_ac      = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end

      S_STA: begin
        ir_on_adr = 1'b1;
        wr_mem    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end

      S_JMP: begin
        ld_pc      = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_ERR: begin
        state_next = S_ERR;
      end

      default: begin
        state_next = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: two instances (default and short wait
// limit) share one stimulus stream; each has its own reference model and queue.
module tb_control_unit;

  localparam int unsigned N_RAND = 2000;

  // Bit positions in the packed output vector.
  localparam int B_IR   = 11;
  localparam int B_PC   = 10;
  localparam int B_LDIR = 9;
  localparam int B_LDAC = 8;
  localparam int B_LDPC = 7;
  localparam int B_INC  = 6;
  localparam int B_CLR  = 5;
  localparam int B_PASS = 4;
  localparam int B_RD   = 3;
  localparam int B_WR   = 2;
  localparam int B_DONE = 1;
  localparam int B_ERR  = 0;

  // Reference-model phases of instruction execution.
  localparam int P_RST    = 0;
  localparam int P_FETCH  = 1;
  localparam int P_DECODE = 2;
  localparam int P_EXEC   = 3;
  localparam int P_ERR    = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] op_code;
  logic       mem_ready;

  logic ir0, pc0, ldir0, ldac0, ldpc0, inc0, clr0, pass0, rd0, wr0, done0, err0;
  logic ir1, pc1, ldir1, ldac1, ldpc1, inc1, clr1, pass1, rd1, wr1, done1, err1;

  control_unit u_dut_def (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .ir_on_adr(ir0), .pc_on_adr(pc0), .ld_ir(ldir0), .ld_ac(ldac0),
    .ld_pc(ldpc0), .inc_pc(inc0), .clr_pc(clr0), .pass_add(pass0),
    .rd_mem(rd0), .wr_mem(wr0), .instr_done(done0), .bus_error(err0)
  );

  control_unit #(.WAIT_LIMIT(3)) u_dut_lim3 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .ir_on_adr(ir1), .pc_on_adr(pc1), .ld_ir(ldir1), .ld_ac(ldac1),
    .ld_pc(ldpc1), .inc_pc(inc1), .clr_pc(clr1), .pass_add(pass1),
    .rd_mem(rd1), .wr_mem(wr1), .instr_done(done1), .bus_error(err1)
  );

  logic [11:0] act0, act1;
  assign act0 = {ir0, pc0, ldir0, ldac0, ldpc0, inc0, clr0, pass0, rd0, wr0, done0, err0};
  assign act1 = {ir1, pc1, ldir1, ldac1, ldpc1, inc1, clr1, pass1, rd1, wr1, done1, err1};

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  string       tag_q[$];

  int tests;
  int fails;

  int         phase[2];
  int         waited[2];
  int         limit[2];
  logic [1:0] op_l[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one cycle of instruction execution for instance k.
  task automatic model_step(input int k, input bit r, input bit mr,
                            input logic [1:0] op, output logic [11:0] e);
    bit mem_done;
    e = '0;
    mem_done = 1'b0;
    case (phase[k])
      P_RST: e[B_CLR] = 1'b1;
      P_FETCH: begin
        e[B_PC] = 1'b1;
        e[B_RD] = 1'b1;
        if (mr) begin
          e[B_LDIR] = 1'b1;
          e[B_INC]  = 1'b1;
        end
      end
      P_EXEC: begin
        case (op_l[k])
          2'd0, 2'd3: begin
            e[B_IR]   = 1'b1;
            e[B_RD]   = 1'b1;
            e[B_PASS] = (op_l[k] == 2'd3);
            e[B_LDAC] = mr;
            e[B_DONE] = mr;
          end
          2'd1: begin
            e[B_IR]   = 1'b1;
            e[B_WR]   = 1'b1;
            e[B_DONE] = mr;
          end
          default: begin
            e[B_LDPC] = 1'b1;
            e[B_DONE] = 1'b1;
          end
        endcase
      end
      P_ERR: e[B_ERR] = 1'b1;
      default: ;
    endcase

    if (!r) begin
      phase[k]  = P_RST;
      waited[k] = 0;
    end else begin
      case (phase[k])
        P_RST: begin
          phase[k]  = P_FETCH;
          waited[k] = 0;
        end
        P_DECODE: begin
          op_l[k]   = op;
          phase[k]  = P_EXEC;
          waited[k] = 0;
        end
        P_FETCH, P_EXEC: begin
          mem_done = (phase[k] == P_EXEC && op_l[k] == 2'd2) || mr;
          if (mem_done) begin
            phase[k]  = (phase[k] == P_FETCH) ? P_DECODE : P_FETCH;
            waited[k] = 0;
          end else if (waited[k] == limit[k]) begin
            phase[k] = P_ERR;
          end else begin
            waited[k] = waited[k] + 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs and queue the expected response of both instances.
  task automatic step(input bit r, input bit mr, input logic [1:0] op, input string tag);
    logic [11:0] e0, e1;
    rst_n     = r;
    mem_ready = mr;
    op_code   = op;
    model_step(0, r, mr, op, e0);
    model_step(1, r, mr, op, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'd0, "rst_low");
    step(1'b1, 1'b0, 2'd0, "rst_state");
  endtask

  // Monitor: compares the settled outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q0.size() > 0) begin
      logic [11:0] e0, e1;
      string t;
      e0 = exp_q0.pop_front();
      e1 = exp_q1.pop_front();
      t  = tag_q.pop_front();
      tests = tests + 1;
      if (act0 !== e0) begin
        fails = fails + 1;
        $display("FAIL %s dut_def t=%0t got %b exp %b", t, $time, act0, e0);
      end
      tests = tests + 1;
      if (act1 !== e1) begin
        fails = fails + 1;
        $display("FAIL %s dut_lim3 t=%0t got %b exp %b", t, $time, act1, e1);
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    limit[0]  = 15;
    limit[1]  = 3;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    op_code   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      phase[k]  = P_RST;
      waited[k] = 0;
      op_l[k]   = 2'd0;
    end

    // Reset then zero-wait LDA.
    step(1'b0, 1'b0, 2'd0, "rst_hold");
    step(1'b1, 1'b0, 2'd0, "rst_release");
    step(1'b1, 1'b1, 2'd0, "lda_fetch");
    step(1'b1, 1'b1, 2'd0, "lda_decode_mr_ignored");
    step(1'b1, 1'b1, 2'd1, "lda_exec");

    // ADD with four wait cycles (limit-3 instance times out).
    step(1'b1, 1'b1, 2'd3, "add_fetch");
    step(1'b1, 1'b0, 2'd3, "add_decode");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, "add_wait");
    step(1'b1, 1'b1, 2'd0, "add_ready");
    step(1'b1, 1'b1, 2'd0, "after_add");

    // STA zero-wait, JMP, STA with two waits.
    do_reset();
    step(1'b1, 1'b1, 2'd1, "sta_fetch");
    step(1'b1, 1'b0, 2'd1, "sta_decode");
    step(1'b1, 1'b1, 2'd2, "sta_exec");
    step(1'b1, 1'b1, 2'd2, "jmp_fetch");
    step(1'b1, 1'b0, 2'd2, "jmp_decode");
    step(1'b1, 1'b1, 2'd0, "jmp_exec");
    step(1'b1, 1'b1, 2'd1, "sta2_fetch");
    step(1'b1, 1'b0, 2'd1, "sta2_decode");
    step(1'b1, 1'b0, 2'd0, "sta2_wait");
    step(1'b1, 1'b0, 2'd0, "sta2_wait");
    step(1'b1, 1'b1, 2'd0, "sta2_ready");

    // FETCH starved: limit-3 instance enters ERR, ignores mem_ready there.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd0, "fetch_starve");
    step(1'b1, 1'b1, 2'd0, "err_mr_ignored");
    step(1'b1, 1'b0, 2'd0, "err_hold");
    do_reset();

    // mem_ready first high exactly on the limit cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, "fetch_near_limit");
    step(1'b1, 1'b1, 2'd2, "fetch_at_limit");
    step(1'b1, 1'b0, 2'd2, "limit_decode");
    step(1'b1, 1'b0, 2'd0, "limit_jmp");

    // Reset during an LDA wait.
    step(1'b1, 1'b1, 2'd0, "ldar_fetch");
    step(1'b1, 1'b0, 2'd0, "ldar_decode");
    step(1'b1, 1'b0, 2'd0, "ldar_wait");
    step(1'b0, 1'b0, 2'd0, "ldar_rst");
    step(1'b1, 1'b1, 2'd0, "ldar_rst_state");
    step(1'b1, 1'b1, 2'd0, "ldar_refetch");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < N_RAND; i++) begin
      bit r, mr;
      logic [1:0] op;
      r  = ($urandom_range(0, 39) != 0);
      mr = ($urandom_range(0, 99) < 55);
      op = 2'($urandom_range(0, 3));
      step(r, mr, op, "random");
    end

    @(negedge clk);
    #1;
    tests = tests + 1;
    if (exp_q0.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain left=%0d exp 0", exp_q0.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
